// File: rtl/pic_host_programmer_if.sv
`default_nettype none
// ============================================================================
//  Module   : pic_host_programmer_if
//  Purpose  : Host request/command handshake plus the 8259 register bus
//             (cs/wr/rd/A0/data) as seen by the host-side programmer.
//  Revision : 1.0  initial release
// ============================================================================
interface pic_host_programmer_if;
    logic       start_init;
    logic [7:0] icw1;
    logic [7:0] icw2;
    logic [7:0] icw3;
    logic [7:0] icw4;
    logic       cmd_valid;
    logic       cmd_rd;
    logic       cmd_a0;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic [7:0] pic_dout;
    logic       cs;
    logic       wr;
    logic       rd;
    logic       a0;
    logic [7:0] din;
    logic       busy;
    logic       init_done;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       err;

    // Programmer side: owns the PIC bus strobes and status outputs
    modport master (
        input  start_init, icw1, icw2, icw3, icw4,
        input  cmd_valid, cmd_rd, cmd_a0, cmd_data, pic_dout,
        output cmd_ready, cs, wr, rd, a0, din,
        output busy, init_done, rd_data, rd_valid, err
    );

    // System-controller side: issues requests and observes the bus
    modport slave (
        output start_init, icw1, icw2, icw3, icw4,
        output cmd_valid, cmd_rd, cmd_a0, cmd_data, pic_dout,
        input  cmd_ready, cs, wr, rd, a0, din,
        input  busy, init_done, rd_data, rd_valid, err
    );
endinterface
`default_nettype wire

// File: rtl/pic_host_programmer.sv
`default_nettype none
// ============================================================================
//  Module   : pic_host_programmer
//  Purpose  : Host-side bus master for the 8259 PIC. Runs the ICW1..ICW4
//             initialization sequence (ICW3/ICW4 skipped as ICW1 dictates),
//             then single OCW writes and status reads with programmable
//             setup/pulse/hold timing.
//  Revision : 1.0  initial release
// ============================================================================
module pic_host_programmer #(
    parameter int SETUP = 1,
    parameter int PULSE = 2,
    parameter int HOLD  = 1
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    pic_host_programmer_if.master  bus
);

    localparam int c_MAX01 = (SETUP > PULSE) ? SETUP : PULSE;
    localparam int c_MAXP  = (c_MAX01 > HOLD) ? c_MAX01 : HOLD;
    localparam int c_CNT_W = (c_MAXP > 1) ? $clog2(c_MAXP) : 1;
    localparam logic [c_CNT_W-1:0] c_SETUP_LD = c_CNT_W'(SETUP - 1);
    localparam logic [c_CNT_W-1:0] c_PULSE_LD = c_CNT_W'(PULSE - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LD  = c_CNT_W'(HOLD - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [1:0]           r_word, w_word_nxt;    // 0..3 = ICW1..ICW4
    logic                 w_last;
    logic [7:0]           w_next_byte;
    logic [1:0]           r_icw1_mode;           // {SNGL, IC4} from ICW1
    logic [7:0]           r_icw2, r_icw3, r_icw4;
    logic                 r_in_init, r_is_rd;
    logic                 r_a0;
    logic [7:0]           r_din;
    logic                 r_cs, r_wr, r_rd;
    logic                 r_init_done;
    logic [7:0]           r_rd_data;
    logic                 r_rd_valid, r_err;

    logic w_idle, w_cnt_zero, w_cmd_ready;
    logic w_acc_init, w_rej_init, w_acc_cmd, w_rd_capture;

    assign w_idle       = (r_state == ST_IDLE);
    assign w_cnt_zero   = (r_cnt == '0);
    assign w_cmd_ready  = w_idle & r_init_done & ~bus.start_init;
    assign w_acc_init   = w_idle & bus.start_init &  bus.icw1[4];
    assign w_rej_init   = w_idle & bus.start_init & ~bus.icw1[4];
    assign w_acc_cmd    = w_cmd_ready & bus.cmd_valid;
    assign w_rd_capture = (r_state == ST_STROBE) & w_cnt_zero & r_is_rd;

    // Pick the next ICW word: ICW3 only in cascade mode, ICW4 only if IC4 set
    always_comb begin
        w_word_nxt = r_word;
        w_last     = 1'b1;
        case (r_word)
            2'd0: begin
                w_word_nxt = 2'd1;
                w_last     = 1'b0;
            end
            2'd1: begin
                if (!r_icw1_mode[1]) begin
                    w_word_nxt = 2'd2;
                    w_last     = 1'b0;
                end else if (r_icw1_mode[0]) begin
                    w_word_nxt = 2'd3;
                    w_last     = 1'b0;
                end
            end
            2'd2: begin
                if (r_icw1_mode[0]) begin
                    w_word_nxt = 2'd3;
                    w_last     = 1'b0;
                end
            end
            default: ;
        endcase
        case (w_word_nxt)
            2'd2:    w_next_byte = r_icw3;
            2'd3:    w_next_byte = r_icw4;
            default: w_next_byte = r_icw2;
        endcase
    end

    // State and phase counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; the counter is reloaded on every phase entry
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_zero ? r_cnt : r_cnt - 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_acc_init || w_acc_cmd) begin
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = c_SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_STROBE;
                    w_cnt_nxt   = c_PULSE_LD;
                end
            end
            ST_STROBE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = c_HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_RECOVER;
                    w_cnt_nxt   = '0;
                end
            end
            ST_RECOVER: begin
                if (r_in_init && !w_last) begin
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = c_SETUP_LD;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Bus strobes registered from the next state so they are glitch-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs <= 1'b1;
            r_wr <= 1'b1;
            r_rd <= 1'b1;
        end else begin
            r_cs <= !((w_state_nxt == ST_SETUP) || (w_state_nxt == ST_STROBE) ||
                      (w_state_nxt == ST_HOLD));
            r_wr <= !((w_state_nxt == ST_STROBE) && !r_is_rd);
            r_rd <= !((w_state_nxt == ST_STROBE) &&  r_is_rd);
        end
    end

    // Request latching, word sequencing, read capture and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_icw1_mode <= 2'b00;
            r_icw2      <= 8'h00;
            r_icw3      <= 8'h00;
            r_icw4      <= 8'h00;
            r_word      <= 2'd0;
            r_in_init   <= 1'b0;
            r_is_rd     <= 1'b0;
            r_a0        <= 1'b0;
            r_din       <= 8'h00;
            r_init_done <= 1'b0;
            r_rd_data   <= 8'h00;
            r_rd_valid  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err      <= w_rej_init;
            r_rd_valid <= w_rd_capture;
            if (w_rd_capture) begin
                r_rd_data <= bus.pic_dout;
            end
            if (w_acc_init) begin
                r_icw1_mode <= bus.icw1[1:0];
                r_icw2      <= bus.icw2;
                r_icw3      <= bus.icw3;
                r_icw4      <= bus.icw4;
                r_word      <= 2'd0;
                r_in_init   <= 1'b1;
                r_is_rd     <= 1'b0;
                r_init_done <= 1'b0;
                r_a0        <= 1'b0;
                r_din       <= bus.icw1;
            end else if (w_acc_cmd) begin
                r_in_init <= 1'b0;
                r_is_rd   <= bus.cmd_rd;
                r_a0      <= bus.cmd_a0;
                r_din     <= bus.cmd_rd ? 8'h00 : bus.cmd_data;
            end else if ((r_state == ST_RECOVER) && r_in_init) begin
                if (w_last) begin
                    r_in_init   <= 1'b0;
                    r_init_done <= 1'b1;
                end else begin
                    r_word <= w_word_nxt;
                    r_a0   <= 1'b1;
                    r_din  <= w_next_byte;
                end
            end
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.cs        = r_cs;
    assign bus.wr        = r_wr;
    assign bus.rd        = r_rd;
    assign bus.a0        = r_a0;
    assign bus.din       = r_din;
    assign bus.busy      = ~w_idle;
    assign bus.init_done = r_init_done;
    assign bus.rd_data   = r_rd_data;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pic_host_programmer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pic_host_programmer
//  Purpose  : Directed, table-driven bench for pic_host_programmer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pic_host_programmer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pic_host_programmer_if bus();

    pic_host_programmer #(.SETUP(1), .PULSE(2), .HOLD(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic [7:0]  i1;
        logic [7:0]  i2;
        logic [7:0]  i3;
        logic [7:0]  i4;
        logic [2:0]  nw;
        logic [31:0] d;    // expected bytes, first word in [31:24]
        logic [3:0]  a;    // expected A0, first word in [3]
    } icw_vec_t;

    icw_vec_t vec [3];

    int n_chk  = 0;
    int n_pass = 0;

    int         obs_nw, obs_ncs, obs_lat, obs_rdlow, obs_rdv, obs_rdv_hold;
    int         obs_viol, obs_rdy_busy;
    logic [7:0] obs_d     [8];
    logic       obs_a     [8];
    int         obs_wrlen [8];
    int         obs_cslen [8];
    logic [7:0] obs_rd_din;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample the bus once per cycle until busy drops (or the budget runs out)
    task automatic observe(input int max_cyc);
        int   wrlen;
        int   cslen;
        logic pwr;
        logic pcs;
        obs_nw = 0; obs_ncs = 0; obs_lat = -1; obs_rdlow = 0; obs_rdv = 0;
        obs_rdv_hold = 0; obs_viol = 0; obs_rdy_busy = 0; obs_rd_din = 8'hxx;
        wrlen = 0; cslen = 0; pwr = 1'b1; pcs = 1'b1;
        for (int cyc = 0; cyc <= max_cyc; cyc++) begin
            if (!bus.wr && pwr && obs_nw < 8) begin
                obs_d[obs_nw] = bus.din;
                obs_a[obs_nw] = bus.a0;
                obs_nw++;
            end
            if (!bus.wr) wrlen++;
            if (bus.wr && !pwr) begin
                if (obs_nw > 0) obs_wrlen[obs_nw-1] = wrlen;
                wrlen = 0;
            end
            if (!bus.cs) cslen++;
            if (bus.cs && !pcs) begin
                if (obs_ncs < 8) obs_cslen[obs_ncs] = cslen;
                obs_ncs++;
                cslen = 0;
            end
            if (!bus.rd) begin
                obs_rdlow++;
                obs_rd_din = bus.din;
            end
            if (bus.rd_valid) begin
                obs_rdv++;
                if (bus.rd && !bus.cs) obs_rdv_hold++;
            end
            if ((!bus.wr && !bus.rd) || ((!bus.wr || !bus.rd) && bus.cs)) obs_viol++;
            if (bus.busy && bus.cmd_ready) obs_rdy_busy++;
            if (cyc > 0 && !bus.busy) begin
                obs_lat = cyc;
                break;
            end
            pwr = bus.wr;
            pcs = bus.cs;
            tick();
        end
    endtask

    task automatic run_init(input icw_vec_t v, input string tag);
        int n;
        bus.icw1 = v.i1; bus.icw2 = v.i2; bus.icw3 = v.i3; bus.icw4 = v.i4;
        bus.start_init = 1'b1;
        tick();
        bus.start_init = 1'b0;
        observe(40);
        n = int'(v.nw);
        check({tag, " words"},   obs_nw,  n);
        check({tag, " latency"}, obs_lat, 5 * n);
        check({tag, " viol"},    obs_viol, 0);
        check({tag, " rdy"},     obs_rdy_busy, 0);
        for (int k = 0; k < n && k < obs_nw; k++) begin
            check($sformatf("%s byte%0d", tag, k),  obs_d[k],     v.d[8*(3-k) +: 8]);
            check($sformatf("%s a0_%0d", tag, k),   obs_a[k],     v.a[3-k]);
            check($sformatf("%s wrlen%0d", tag, k), obs_wrlen[k], 2);
            check($sformatf("%s cslen%0d", tag, k), obs_cslen[k], 4);
        end
        check({tag, " init_done"}, bus.init_done, 1'b1);
        check({tag, " cmd_ready"}, bus.cmd_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cs_low;
        vec[0] = '{i1: 8'h13, i2: 8'h20, i3: 8'h00, i4: 8'h01, nw: 3'd3,
                   d: 32'h1320_0100, a: 4'b0110};
        vec[1] = '{i1: 8'h11, i2: 8'h08, i3: 8'h04, i4: 8'h03, nw: 3'd4,
                   d: 32'h1108_0403, a: 4'b0111};
        vec[2] = '{i1: 8'h12, i2: 8'h40, i3: 8'h77, i4: 8'h55, nw: 3'd2,
                   d: 32'h1240_0000, a: 4'b0100};

        bus.start_init = 1'b0; bus.icw1 = 8'h00; bus.icw2 = 8'h00;
        bus.icw3 = 8'h00; bus.icw4 = 8'h00; bus.cmd_valid = 1'b0;
        bus.cmd_rd = 1'b0; bus.cmd_a0 = 1'b0; bus.cmd_data = 8'h00;
        bus.pic_dout = 8'h00;

        // Reset state
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst cs", bus.cs, 1'b1);
        check("rst wr", bus.wr, 1'b1);
        check("rst rd", bus.rd, 1'b1);
        check("rst a0", bus.a0, 1'b0);
        check("rst din", bus.din, 8'h00);
        check("rst busy", bus.busy, 1'b0);
        check("rst init_done", bus.init_done, 1'b0);
        check("rst cmd_ready", bus.cmd_ready, 1'b0);
        check("rst rd_data", bus.rd_data, 8'h00);
        check("rst rd_valid", bus.rd_valid, 1'b0);
        check("rst err", bus.err, 1'b0);

        // Command before initialization is never accepted
        bus.cmd_valid = 1'b1; bus.cmd_a0 = 1'b1; bus.cmd_data = 8'hAA;
        #1;
        check("preinit cmd_ready", bus.cmd_ready, 1'b0);
        cs_low = 0;
        repeat (6) begin
            tick();
            if (!bus.cs) cs_low++;
        end
        check("preinit cs activity", cs_low, 0);
        bus.cmd_valid = 1'b0;

        // ICW sequences from the table
        for (int i = 0; i < 3; i++) run_init(vec[i], $sformatf("init%0d", i));

        // Rejected ICW1 (D4 clear)
        bus.icw1 = 8'h03;
        bus.start_init = 1'b1;
        tick();
        bus.start_init = 1'b0;
        check("rej err", bus.err, 1'b1);
        check("rej cs", bus.cs, 1'b1);
        check("rej busy", bus.busy, 1'b0);
        check("rej init_done", bus.init_done, 1'b1);
        tick();
        check("rej err pulse", bus.err, 1'b0);
        check("rej cs2", bus.cs, 1'b1);

        // OCW write
        bus.cmd_valid = 1'b1; bus.cmd_rd = 1'b0; bus.cmd_a0 = 1'b1; bus.cmd_data = 8'hFB;
        #1;
        check("wr cmd_ready", bus.cmd_ready, 1'b1);
        tick();
        bus.cmd_valid = 1'b0;
        observe(20);
        check("wr words", obs_nw, 1);
        check("wr din", obs_d[0], 8'hFB);
        check("wr a0", obs_a[0], 1'b1);
        check("wr wrlen", obs_wrlen[0], 2);
        check("wr latency", obs_lat, 5);
        check("wr rdy busy", obs_rdy_busy, 0);
        check("wr ready after", bus.cmd_ready, 1'b1);

        // Status read
        bus.pic_dout = 8'h5A;
        bus.cmd_valid = 1'b1; bus.cmd_rd = 1'b1; bus.cmd_a0 = 1'b0; bus.cmd_data = 8'h99;
        tick();
        bus.cmd_valid = 1'b0;
        observe(20);
        check("rd wr strobes", obs_nw, 0);
        check("rd low", obs_rdlow, 2);
        check("rd din", obs_rd_din, 8'h00);
        check("rd data", bus.rd_data, 8'h5A);
        check("rd valid pulses", obs_rdv, 1);
        check("rd valid in hold", obs_rdv_hold, 1);
        check("rd cs len", obs_cslen[0], 4);
        check("rd viol", obs_viol, 0);
        check("rd latency", obs_lat, 5);
        check("rd rdy busy", obs_rdy_busy, 0);
        check("rd ready after", bus.cmd_ready, 1'b1);

        // start_init and cmd_valid together: init wins
        bus.icw1 = vec[0].i1; bus.icw2 = vec[0].i2; bus.icw3 = vec[0].i3; bus.icw4 = vec[0].i4;
        bus.cmd_valid = 1'b1; bus.cmd_rd = 1'b0; bus.cmd_a0 = 1'b1; bus.cmd_data = 8'hEE;
        bus.start_init = 1'b1;
        #1;
        check("both cmd_ready", bus.cmd_ready, 1'b0);
        tick();
        bus.start_init = 1'b0;
        bus.cmd_valid = 1'b0;
        observe(40);
        check("both words", obs_nw, 3);
        check("both first byte", obs_d[0], 8'h13);
        check("both first a0", obs_a[0], 1'b0);
        check("both init_done", bus.init_done, 1'b1);

        // Reset asserted during the ICW2 strobe
        bus.start_init = 1'b1;
        tick();
        bus.start_init = 1'b0;
        repeat (6) tick();
        check("mid wr low", bus.wr, 1'b0);
        check("mid din", bus.din, 8'h20);
        rst_n = 1'b0;
        #1;
        check("mid rst wr", bus.wr, 1'b1);
        check("mid rst cs", bus.cs, 1'b1);
        check("mid rst init_done", bus.init_done, 1'b0);
        check("mid rst busy", bus.busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_init(vec[0], "restart");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pic_host_programmer.md
Name: pic_host_programmer

Overview:
- Host-side bus master for the 8259 PIC register interface; it drives cs, rd, wr and A0 and the data bus toward the PIC.
- On request, it issues the ICW1..ICW4 initialization sequence, skipping ICW3 and ICW4 as ICW1 dictates.
- After initialization, it performs single OCW writes and status reads (IRR/ISR/IMR) for the system controller, with programmable bus timing.

Parameters:
- SETUP, 1, cycles cs/A0/data are stable before the strobe falls (>=1)
- PULSE, 2, cycles the wr or rd strobe is held low (>=1)
- HOLD, 1, cycles cs/A0/data are held after the strobe rises (>=1)

Ports:
- clk  in  1  single system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start_init  in  1  one-cycle request to run the ICW sequence
- icw1, icw2, icw3, icw4  in  8 each  ICW bytes, sampled at start_init acceptance
- cmd_valid  in  1  command request
- cmd_rd  in  1  1 = read cycle, 0 = write cycle
- cmd_a0  in  1  A0 value for the command
- cmd_data  in  8  write data (ignored for reads)
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- pic_dout  in  8  read data returned by the PIC
- cs  out  1  chip select, active low
- wr  out  1  write strobe, active low
- rd  out  1  read strobe, active low
- a0  out  1  PIC address line
- din  out  8  data to the PIC
- busy  out  1  a bus cycle or sequence is in progress
- init_done  out  1  high once the full ICW sequence has completed
- rd_data  out  8  last captured read value
- rd_valid  out  1  one-cycle pulse when rd_data updates
- err  out  1  one-cycle pulse when an ICW1 is rejected

Behaviour:
- Reset (async, immediate): cs=wr=rd=1, a0=0, din=0, busy=0, init_done=0, cmd_ready=0, rd_data=0, rd_valid=0, err=0; FSM goes to IDLE and the sequence pointer clears. Strobes rise immediately even mid-cycle.
- FSM states: IDLE, SETUP, STROBE, HOLD, RECOVER. A shared down-counter is loaded on each state entry.
- Bus cycle:
  - SETUP: cs=0, a0 and din driven, for SETUP cycles.
  - STROBE: wr=0 or rd=0 for PULSE cycles.
  - HOLD: strobe=1, cs=0, a0 and din unchanged, for HOLD cycles.
  - RECOVER: cs=1 for 1 cycle, then the next word or IDLE.
  - Total cycle length is SETUP+PULSE+HOLD+1 = 5 clocks at defaults.
- Read capture: pic_dout is registered into rd_data at the edge that ends STROBE; rd_valid pulses in the first HOLD cycle.
- busy is high in every state except IDLE, and stays high between ICW words.
- start_init in IDLE:
  - If icw1[4]=0: err pulses the next cycle, no bus activity occurs, and init_done is unchanged.
  - Otherwise: latch all four ICW bytes, clear init_done, and write ICW1 with a0=0, then ICW2 with a0=1.
  - Write ICW3 (a0=1) only if icw1[1]=0; write ICW4 (a0=1) only if icw1[0]=1.
  - init_done=1 on the cycle IDLE is re-entered after the last word.
- start_init while busy: ignored. start_init after init_done: re-initializes.
- cmd_ready = (state==IDLE) & init_done & ~start_init; it is 0 throughout a sequence.
- Accepting a command latches cmd_rd, cmd_a0 and cmd_data and runs exactly one bus cycle, with din = cmd_data for writes and din=0 for reads.
- Simultaneous start_init and cmd_valid in IDLE: start_init wins and the command is not accepted.
- The block does no content checking of OCW bytes; the host owns encoding.
- wr and rd are never low in the same cycle; cs is always low whenever either strobe is low.

Test Plan:
- Reset, then icw1=0x13, icw2=0x20, icw4=0x01, start_init -> writes 0x13/a0=0, 0x20/a0=1, 0x01/a0=1 with no ICW3; each wr low 2 clocks inside a 4-clock cs low; init_done rises 15 clocks after start.
- icw1=0x11, icw2=0x08, icw3=0x04, icw4=0x03 -> four writes in order 0x11, 0x08, 0x04, 0x03 (A0 pattern 0,1,1,1); init_done after 20 clocks.
- icw1=0x12 -> only ICW1 and ICW2 are written; init_done after 10 clocks. Then icw1=0x03 -> err pulses once, cs stays 1, init_done stays 1.
- After init: write cmd a0=1, data=0xFB -> one write cycle with din=0xFB, a0=1. Then read cmd a0=0 with pic_dout=0x5A -> rd low 2 clocks, rd_data=0x5A, rd_valid one pulse; cmd_ready=0 throughout, then 1 again in IDLE.
- cmd_valid before init_done -> cmd_ready=0, no cs activity. start_init and cmd_valid in the same IDLE cycle -> the ICW sequence runs and the command is not accepted.
- rst_n low during the STROBE of ICW2 -> wr=cs=1 immediately and init_done=0. After release, a new start_init restarts from ICW1.
